// File: rtl/fetch_pkg.sv
// Shared types, constants and PC arithmetic for the fetch sequencer.
package fetch_pkg;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned PC_W  = 5;
    localparam int unsigned IW    = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [IW-1:0] HALT_WORD = 16'hF000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StHalt = 2'd3
    } state_t;

    // 8-bit two's complement add, truncated so the PC wraps modulo DEPTH.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                               input logic [7:0]      off8);
        logic [7:0] sum;
        sum = {{(8 - PC_W){1'b0}}, pc} + off8;
        return sum[PC_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer (master) and its surroundings (slave).
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic             load_start;
    logic             run_start;
    logic             halt_req;
    logic             load_valid;
    logic             load_ready;
    logic [PC_W-1:0]  load_addr;
    logic [IW-1:0]    load_data;
    logic             load_last;
    logic             imem_we;
    logic [PC_W-1:0]  imem_waddr;
    logic [IW-1:0]    imem_wdata;
    logic [PC_W-1:0]  imem_raddr;
    logic [IW-1:0]    imem_rdata;
    logic [IW-1:0]    instr;
    logic             instr_valid;
    logic             stall;
    logic             jump;
    logic             branch_taken;
    logic [7:0]       branch_off;
    logic [PC_W-1:0]  pc;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  load_start, run_start, halt_req, load_valid, load_addr, load_data, load_last,
               imem_rdata, stall, jump, branch_taken, branch_off,
        output load_ready, imem_we, imem_waddr, imem_wdata, imem_raddr, instr, instr_valid,
               pc, state, halted, retired_cnt
    );

    modport slave (
        output load_start, run_start, halt_req, load_valid, load_addr, load_data, load_last,
               imem_rdata, stall, jump, branch_taken, branch_off,
        input  load_ready, imem_we, imem_waddr, imem_wdata, imem_raddr, instr, instr_valid,
               pc, state, halted, retired_cnt
    );

endinterface

// File: rtl/fetch_load_port.sv
// Loader valid/ready handshake and the registered instruction-memory write stage.
module fetch_load_port
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            valid_i,
    input  logic [PC_W-1:0] addr_i,
    input  logic [IW-1:0]   data_i,
    output logic            ready_o,
    output logic            accept_o,
    output logic            we_o,
    output logic [PC_W-1:0] waddr_o,
    output logic [IW-1:0]   wdata_o
);

    logic            we_d, we_q;
    logic [PC_W-1:0] waddr_d, waddr_q;
    logic [IW-1:0]   wdata_d, wdata_q;

    assign ready_o  = en_i;
    assign accept_o = en_i & valid_i;

    // Capture an accepted beat; address/data hold when idle.
    always_comb begin
        we_d    = accept_o;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept_o) begin
            waddr_d = addr_i;
            wdata_d = data_i;
        end
    end

    // Write stage registers; reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Load/run/halt sequencer owning the PC and the retired-instruction counter.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic            in_run;
    logic            accept;
    logic            is_halt_word;
    logic [PC_W-1:0] pc_next;

    assign in_run       = (state_q == StRun);
    assign is_halt_word = (bus.imem_rdata == HALT_WORD);

    fetch_load_port u_load_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q == StLoad),
        .valid_i  (bus.load_valid),
        .addr_i   (bus.load_addr),
        .data_i   (bus.load_data),
        .ready_o  (bus.load_ready),
        .accept_o (accept),
        .we_o     (bus.imem_we),
        .waddr_o  (bus.imem_waddr),
        .wdata_o  (bus.imem_wdata)
    );

    // Advancing next-PC: jump beats branch beats increment.
    always_comb begin
        pc_next = pc_add(pc_q, 8'd1);
        if (bus.jump) begin
            pc_next = pc_add(pc_q, bus.imem_rdata[7:0]);
        end else if (bus.branch_taken) begin
            pc_next = pc_add(pc_q, bus.branch_off);
        end
    end

    // Phase FSM together with PC and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.load_start) begin
                        state_q <= StLoad;
                    end else if (bus.run_start) begin
                        state_q <= StRun;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                StLoad: begin
                    if (accept && bus.load_last) begin
                        state_q <= StHalt;
                    end
                end
                StRun: begin
                    if (bus.halt_req) begin
                        state_q <= StHalt;
                    end else if (bus.stall) begin
                        state_q <= StRun;
                    end else if (is_halt_word) begin
                        // PC parks on the halt word so a resume re-halts.
                        state_q <= StHalt;
                    end else begin
                        pc_q <= pc_next;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StHalt: begin
                    if (bus.load_start) begin
                        state_q <= StLoad;
                    end else if (bus.run_start) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_raddr  = pc_q;
    assign bus.instr       = in_run ? bus.imem_rdata : '0;
    assign bus.instr_valid = in_run & ~bus.stall;
    assign bus.pc          = pc_q;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == StHalt);
    assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: table-driven RUN vectors plus hand sequences, write scoreboard.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [32];
    assign bus.imem_rdata = mem[bus.imem_raddr];

    always @(posedge clk) begin
        if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
    end

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write scoreboard: push on accepted beat, pop when the write appears.
    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t wq[$];
    wr_t wexp;

    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete();
        end else begin
            if (bus.imem_we) begin
                we_cnt++;
                if (wq.size() == 0) begin
                    chk("spurious_write", 32'(bus.imem_we), 32'd0);
                end else begin
                    wexp = wq.pop_front();
                    chk("waddr", 32'(bus.imem_waddr), 32'(wexp.a));
                    chk("wdata", 32'(bus.imem_wdata), 32'(wexp.d));
                end
            end
            if (bus.load_valid && bus.load_ready) wq.push_back('{bus.load_addr, bus.load_data});
        end
    end

    typedef struct {
        logic [4:0] pc_in;
        logic       j;
        logic       b;
        logic [7:0] off;
        logic       s;
        logic       h;
        logic [4:0] pc_exp;
        logic [1:0] st_exp;
        logic       ret;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] pc_in, input logic j, input logic b,
                                input logic [7:0] off, input logic s, input logic h,
                                input logic [4:0] pc_exp, input logic [1:0] st_exp,
                                input logic ret);
        vec_t v;
        v.pc_in = pc_in; v.j = j; v.b = b; v.off = off; v.s = s; v.h = h;
        v.pc_exp = pc_exp; v.st_exp = st_exp; v.ret = ret;
        return v;
    endfunction

    vec_t vecs [13];
    int   exp_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.load_start = 0; bus.run_start = 0; bus.halt_req = 0;
        bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0; bus.load_last = 0;
        bus.stall = 0; bus.jump = 0; bus.branch_taken = 0; bus.branch_off = '0;
    endtask

    task automatic beat(input logic [4:0] a, input logic [15:0] d, input logic last);
        bus.load_valid = 1; bus.load_addr = a; bus.load_data = d; bus.load_last = last;
        tick();
        bus.load_valid = 0; bus.load_last = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_waddr", 32'(bus.imem_waddr), 32'd0);
        chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("rst_cnt", 32'(bus.retired_cnt), 32'd0);
        chk("rst_ready", 32'(bus.load_ready), 32'd0);
        chk("rst_ivalid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Program load: three beats, last one ends in HALT with a trailing write
        bus.load_start = 1;
        tick();
        bus.load_start = 0;
        chk("load_state", 32'(bus.state), 32'd1);
        chk("load_ready", 32'(bus.load_ready), 32'd1);
        beat(5'd0, 16'h0401, 1'b0);
        beat(5'd1, 16'h0402, 1'b0);
        beat(5'd2, 16'hF000, 1'b1);
        chk("load_to_halt", 32'(bus.state), 32'd3);
        chk("trailing_we", 32'(bus.imem_we), 32'd1);
        tick();
        chk("we_drop", 32'(bus.imem_we), 32'd0);
        tick();
        chk("we_cycles", 32'(we_cnt), 32'd3);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("load_pc_hold", 32'(bus.pc), 32'd0);

        // Run the loaded program until it self-halts
        bus.run_start = 1;
        tick();
        bus.run_start = 0;
        chk("run_state", 32'(bus.state), 32'd2);
        for (int i = 0; i < 20 && !bus.halted; i++) tick();
        chk("prog_halted", 32'(bus.halted), 32'd1);
        chk("prog_pc", 32'(bus.pc), 32'd2);
        chk("prog_cnt", 32'(bus.retired_cnt), 32'd2);

        // Resume on the halt word: one RUN cycle, then straight back to HALT
        bus.run_start = 1;
        tick();
        bus.run_start = 0;
        chk("rehalt_run", 32'(bus.state), 32'd2);
        tick();
        chk("rehalt_state", 32'(bus.state), 32'd3);
        chk("rehalt_pc", 32'(bus.pc), 32'd2);
        chk("rehalt_cnt", 32'(bus.retired_cnt), 32'd2);

        // Table-driven next-PC checks from a fresh run at pc 0
        for (int i = 0; i < 32; i++) mem[i] = 16'h0100;
        mem[0]  = 16'h0014;
        mem[20] = 16'h0003;
        mem[30] = 16'h0002;
        vecs[0]  = mk(5'd0,  1, 0, 8'h00, 0, 0, 5'd20, 2'd2, 1);
        vecs[1]  = mk(5'd20, 1, 0, 8'h00, 0, 0, 5'd23, 2'd2, 1);
        vecs[2]  = mk(5'd23, 0, 1, 8'hF7, 0, 0, 5'd14, 2'd2, 1);
        vecs[3]  = mk(5'd14, 0, 1, 8'h06, 0, 0, 5'd20, 2'd2, 1);
        vecs[4]  = mk(5'd20, 1, 0, 8'h00, 1, 0, 5'd20, 2'd2, 0);
        vecs[5]  = mk(5'd20, 1, 0, 8'h00, 1, 0, 5'd20, 2'd2, 0);
        vecs[6]  = mk(5'd20, 1, 0, 8'h00, 1, 0, 5'd20, 2'd2, 0);
        vecs[7]  = mk(5'd20, 1, 0, 8'h00, 0, 0, 5'd23, 2'd2, 1);
        vecs[8]  = mk(5'd23, 0, 1, 8'h08, 0, 0, 5'd31, 2'd2, 1);
        vecs[9]  = mk(5'd31, 0, 0, 8'h00, 0, 0, 5'd0,  2'd2, 1);
        vecs[10] = mk(5'd0,  0, 1, 8'hFE, 0, 0, 5'd30, 2'd2, 1);
        vecs[11] = mk(5'd30, 1, 1, 8'h05, 0, 0, 5'd0,  2'd2, 1);
        vecs[12] = mk(5'd0,  1, 0, 8'h00, 0, 1, 5'd0,  2'd3, 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.run_start = 1;
        tick();
        bus.run_start = 0;
        exp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            bus.jump = vecs[i].j; bus.branch_taken = vecs[i].b; bus.branch_off = vecs[i].off;
            bus.stall = vecs[i].s; bus.halt_req = vecs[i].h;
            #1;
            chk($sformatf("v%0d_pc_in", i), 32'(bus.pc), 32'(vecs[i].pc_in));
            chk($sformatf("v%0d_instr", i), 32'(bus.instr), 32'(mem[vecs[i].pc_in]));
            chk($sformatf("v%0d_ivalid", i), 32'(bus.instr_valid), 32'(!vecs[i].s));
            tick();
            if (vecs[i].ret) exp_cnt++;
            chk($sformatf("v%0d_pc", i), 32'(bus.pc), 32'(vecs[i].pc_exp));
            chk($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].st_exp));
            chk($sformatf("v%0d_cnt", i), 32'(bus.retired_cnt), 32'(exp_cnt));
        end
        clear_inputs();
        chk("halt_ivalid", 32'(bus.instr_valid), 32'd0);

        // Resume after halt_req: same pc, count continues
        bus.run_start = 1;
        tick();
        bus.run_start = 0;
        chk("resume_pc", 32'(bus.pc), 32'd0);
        bus.jump = 1;
        tick();
        bus.jump = 0;
        exp_cnt++;
        chk("resume_jump_pc", 32'(bus.pc), 32'd20);
        chk("resume_cnt", 32'(bus.retired_cnt), 32'(exp_cnt));
        bus.halt_req = 1;
        tick();
        bus.halt_req = 0;
        chk("halt_again", 32'(bus.state), 32'd3);

        // Reset in the middle of a load drops the pending write
        bus.load_start = 1;
        tick();
        bus.load_start = 0;
        beat(5'd5, 16'h1234, 1'b0);
        chk("mid_we_pending", 32'(bus.imem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.imem_we), 32'd0);
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_pc", 32'(bus.pc), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.load_valid = 1; bus.load_addr = 5'd6; bus.load_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ready", 32'(bus.load_ready), 32'd0);
            chk("post_rst_we", 32'(bus.imem_we), 32'd0);
        end
        bus.load_valid = 0;
        tick();
        chk("end_wq_empty", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block for the 32-entry instruction memory and program counter. Sequences the core through program load, run and halt phases. Arbitrates the memory write port between a program loader (valid/ready) and the run phase. Owns the PC and selects next-PC from jump, branch or increment; the decode logic drives the jump and branch inputs.

Parameters:
DEPTH, 32, instruction words in memory
PC_W, 5, PC / address width (log2 DEPTH)
IW, 16, instruction width
HALT_WORD, 16'hF000, fetched word that self-halts the core
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
load_start  in  1  pulse: enter LOAD (honoured in IDLE/HALT only)
run_start  in  1  pulse: enter RUN (honoured in IDLE/HALT only)
halt_req  in  1  level: stop fetch at end of cycle
load_valid  in  1  loader beat valid
load_ready  out  1  loader beat accepted when valid&ready
load_addr  in  PC_W  loader word address
load_data  in  IW  loader word
load_last  in  1  final beat of program
imem_we  out  1  memory write enable (registered)
imem_waddr  out  PC_W  memory write address (registered)
imem_wdata  out  IW  memory write data (registered)
imem_raddr  out  PC_W  memory read address, equals pc
imem_rdata  in  IW  asynchronous read data
instr  out  IW  current instruction (imem_rdata gated)
instr_valid  out  1  instr is live this cycle
stall  in  1  hold PC, do not retire
jump  in  1  decode: jump, offset instr[7:0]
branch_taken  in  1  decode: branch taken, offset branch_off
branch_off  in  8  sign-extended branch offset
pc  out  PC_W  program counter
state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
halted  out  1  state==HALT
retired_cnt  out  CNT_W  instructions retired since last run_start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, imem_we=0, imem_waddr=0, imem_wdata=0, retired_cnt=0, load_ready=0, instr_valid=0, instr=0.
- IDLE: load_start->LOAD; run_start->RUN with pc=0 and retired_cnt=0. If both fire, load_start wins.
- LOAD: load_ready=1.
  - Each accepted beat registers imem_we=1, waddr=load_addr, wdata=load_data on the next edge. Write lands 1 cycle after acceptance.
  - Accepted beat with load_last -> HALT; the final write still issues in the first HALT cycle.
  - run_start, halt_req, jump and branch are ignored in LOAD. pc holds.
- RUN: load_ready=0; instr=imem_rdata; instr_valid=~stall.
  - Next-PC priority: halt_req > stall (hold) > jump (pc+instr[7:0]) > branch_taken (pc+branch_off) > pc+1.
  - All PC arithmetic is 8-bit two's complement truncated to PC_W: wraps mod 32 (31+1=0; 2+8'hFE=0).
  - Retire = RUN & ~stall & ~halt_req & (instr!=HALT_WORD). retired_cnt increments on each retire and saturates at all-ones.
  - instr==HALT_WORD and ~stall -> HALT, pc holds on the halt word, no retire.
  - halt_req -> HALT, pc holds, no retire.
  - load_start and run_start are ignored in RUN.
- HALT: instr_valid=0, pc holds.
  - run_start resumes RUN at the current pc, retired_cnt kept. If pc addresses HALT_WORD, the core re-halts immediately.
  - load_start -> LOAD.
- A reset mid-LOAD drops any registered pending write (imem_we=0). Memory contents are external and untouched.
- imem_we is never high in RUN except the single trailing write cycle defined above.

Decomposition:
- Shared package fetch_pkg holds:
  - the state_t enum (IDLE, LOAD, RUN, HALT)
  - PC_W, IW and HALT_WORD constants
  - next-PC function pc_add(pc, off8) returning the PC_W-bit wrap sum.
- One sub-module, fetch_load_port: loader handshake plus the registered write stage (we/addr/data). The top keeps the FSM, PC and counter.

Test Plan:
- Reset, then load_start and 3 beats (addr 0,1,2 = 16'h0401, 16'h0402, 16'hF000, last on beat 3) -> imem_we high for 3 cycles, each 1 cycle after its beat; state ends HALT.
- run_start with no jump/branch -> pc 0->1->2, halts on 16'hF000 at pc=2; retired_cnt=2; halted=1.
- RUN at pc=20, jump with instr[7:0]=8'h03 -> pc=23 next cycle. At pc=14, branch_taken with off=8'h06 -> pc=20. At pc=31, increment -> pc=0.
- stall high 3 cycles together with jump -> pc holds and retired_cnt is unchanged; stall drops -> jump taken.
- halt_req and jump in the same cycle -> HALT, pc unchanged. run_start -> resumes at the same pc, count continues.
- Assert rst_n low mid-LOAD after an accepted beat -> imem_we=0 immediately, state=IDLE, pc=0; load_valid is then ignored until load_start.
